// File: rtl/alu_operand_stack_if.sv
// Command/operand bundle between the control unit, the ALU and the operand stack.
// The control side (master) issues commands and returns the ALU result.
// The stack side (slave) presents the operands and the status flags.
interface alu_operand_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [2:0]       cmd;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] alu_r;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             err;

  modport master (
    output cmd, din, alu_r,
    input  a, b, count, empty, full, err
  );

  modport slave (
    input  cmd, din, alu_r,
    output a, b, count, empty, full, err
  );
endinterface

// File: rtl/alu_operand_stack.sv
// Operand stack for the 16-bit stack-processor ALU.
// Presents NOS/TOS as ALU operands a/b and folds the ALU result back in a
// single pop-two-push-one step. Also executes PUSH/POP/DUP/SWAP/OVER.
// An illegal command leaves the stack untouched and raises err for one cycle.
module alu_operand_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_operand_stack_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_PUSH = 3'd1,
    CMD_POP  = 3'd2,
    CMD_ALU  = 3'd3,
    CMD_DUP  = 3'd4,
    CMD_SWAP = 3'd5,
    CMD_OVER = 3'd6,
    CMD_NOP7 = 3'd7
  } cmd_e;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    sp;
  logic [CW-1:0]    sp_nxt;
  logic             err_q;
  logic             illegal;

  // Slot addresses relative to the stack pointer. Only used when the
  // corresponding legality check guarantees they are in range.
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    tos_idx;
  logic [AW-1:0]    nos_idx;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic             has1;
  logic             has2;
  logic             room;

  // Up to two array writes per cycle (SWAP needs both).
  logic             we0;
  logic [AW-1:0]    idx0;
  logic [WIDTH-1:0] d0;
  logic             we1;
  logic [AW-1:0]    idx1;
  logic [WIDTH-1:0] d1;

  assign top_idx = AW'(sp);
  assign tos_idx = AW'(sp - CW'(1));
  assign nos_idx = AW'(sp - CW'(2));
  assign tos     = mem[tos_idx];
  assign nos     = mem[nos_idx];
  assign has1    = (sp != '0);
  assign has2    = (sp >= CW'(2));
  assign room    = (sp < CW'(DEPTH));

  // Decode the command: legality check, next stack pointer and array writes.
  always_comb begin
    illegal = 1'b0;
    sp_nxt  = sp;
    we0     = 1'b0;
    idx0    = top_idx;
    d0      = bus.din;
    we1     = 1'b0;
    idx1    = nos_idx;
    d1      = tos;
    case (cmd_e'(bus.cmd))
      CMD_PUSH: begin
        if (room) begin
          we0    = 1'b1;
          d0     = bus.din;
          sp_nxt = sp + CW'(1);
        end else begin
          illegal = 1'b1;
        end
      end
      CMD_POP: begin
        if (has1) sp_nxt = sp - CW'(1);
        else      illegal = 1'b1;
      end
      CMD_ALU: begin
        // Result replaces NOS; TOS slot is abandoned by the pointer decrement.
        if (has2) begin
          we0    = 1'b1;
          idx0   = nos_idx;
          d0     = bus.alu_r;
          sp_nxt = sp - CW'(1);
        end else begin
          illegal = 1'b1;
        end
      end
      CMD_DUP: begin
        if (has1 && room) begin
          we0    = 1'b1;
          d0     = tos;
          sp_nxt = sp + CW'(1);
        end else begin
          illegal = 1'b1;
        end
      end
      CMD_SWAP: begin
        if (has2) begin
          we0  = 1'b1;
          idx0 = tos_idx;
          d0   = nos;
          we1  = 1'b1;
          idx1 = nos_idx;
          d1   = tos;
        end else begin
          illegal = 1'b1;
        end
      end
      CMD_OVER: begin
        if (has2 && room) begin
          we0    = 1'b1;
          d0     = nos;
          sp_nxt = sp + CW'(1);
        end else begin
          illegal = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Stack storage; cleared on reset so stale data never reaches the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (we0) mem[idx0] <= d0;
      if (we1) mem[idx1] <= d1;
    end
  end

  // Stack pointer and the one-cycle illegal-command pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp    <= '0;
      err_q <= 1'b0;
    end else begin
      sp    <= sp_nxt;
      err_q <= illegal;
    end
  end

  assign bus.b     = has1 ? tos : '0;
  assign bus.a     = has2 ? nos : '0;
  assign bus.count = sp;
  assign bus.empty = (sp == '0);
  assign bus.full  = (sp == CW'(DEPTH));
  assign bus.err   = err_q;
endmodule

// File: doc/alu_operand_stack.md
# alu_operand_stack

Operand stack feeding the 16-bit ALU of the stack processor: it presents the two topmost entries as ALU operands `a`/`b` and absorbs the ALU result `r` back onto the stack in a single pop-two-push-one step. It sits between the control unit, which issues one stack command per cycle, and the combinational ALU, closing the operand/result loop. Besides plain push/pop it also executes the stack-manipulation commands DUP, SWAP and OVER, and it flags illegal commands without corrupting state.

## Interface
Parameters:
- `WIDTH`, 16: data width; matches ALU `a`/`b`/`r`.
- `DEPTH`, 16: number of entries, ≥ 2.

Ports:
- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst_n`, input, 1: **asynchronous, active-low reset.**
- `cmd`, input, 3: command applied at the next rising edge.
  - 0 NOP
  - 1 PUSH
  - 2 POP
  - 3 ALU
  - 4 DUP
  - 5 SWAP
  - 6 OVER
  - 7 NOP
- `din`, input, WIDTH: value pushed by PUSH.
- `alu_r`, input, WIDTH: ALU result, written by the ALU command.
- `a`, output, WIDTH: next-on-stack (NOS) operand, ALU `a`.
- `b`, output, WIDTH: top-of-stack (TOS) operand, ALU `b`.
- `count`, output, $clog2(DEPTH+1): number of valid entries.
- `empty`, output, 1: `count == 0`.
- `full`, output, 1: `count == DEPTH`.
- `err`, output, 1: registered one-cycle pulse; the previous command was illegal.

## Operation
- Storage is a register array `mem[0..DEPTH-1]` plus stack pointer `sp` (equal to `count`).
- TOS is `mem[sp-1]`; NOS is `mem[sp-2]`.
- Operand outputs:
  - `b` = TOS when count ≥ 1, else 0.
  - `a` = NOS when count ≥ 2, else 0.
  - Both are combinational from registers, so the ALU sees stable operands for the whole cycle.
- Operand order is fixed: the earlier-pushed value is `a`. Pushing 64 then 27 and running a subtract gives 64−27.
- Commands and legality requirements:
  - PUSH (requires count < DEPTH): `mem[sp] ← din`, sp+1.
  - POP (requires count ≥ 1): sp−1. The entry is not cleared.
  - ALU (requires count ≥ 2): `mem[sp-2] ← alu_r`, sp−1. This is the pop-two-push-one step.
  - DUP (requires 1 ≤ count < DEPTH): `mem[sp] ← TOS`, sp+1.
  - SWAP (requires count ≥ 2): exchange TOS and NOS; sp unchanged.
  - OVER (requires 2 ≤ count < DEPTH): `mem[sp] ← NOS`, sp+1.
- Illegal command (requirement violated):
  - No change to `mem` or `sp`.
  - `err` = 1 for exactly the following cycle.
- Legal command or NOP: `err` = 0 in the following cycle.
- Arithmetic: `sp` never wraps. Overflow and underflow are prevented solely by the legality checks above. `alu_r` is stored unmodified; ALU overflow/zero flags are not consumed here.

## Timing
- Reset (`rst_n` low, asynchronous, at any time including mid-command):
  - `sp` = 0, `err` = 0, all `mem` entries = 0.
  - Resulting outputs: `a` = 0, `b` = 0, `count` = 0, `empty` = 1, `full` = 0.
- Release: the first command is sampled on the first rising edge with `rst_n` high.
- Latency: a command sampled at edge N is visible on `a`/`b`/`count`/`empty`/`full` immediately after edge N. There are no stall cycles; throughput is one command per cycle.
- ALU loop: `alu_r` is sampled at the same edge as the ALU command. The ALU is combinational on `a`/`b`, so the full path is one cycle.
- `err` for the command at edge N is asserted after edge N and cleared after edge N+1, unless the command at N+1 is also illegal.
- Boundary rules:
  - PUSH/DUP/OVER at full → err, state held.
  - POP/DUP at empty → err.
  - ALU/SWAP/OVER with count = 1 → err.
  - Reaching `count == DEPTH` asserts `full` after that same edge.

## Test plan
- **Reset mid-stream:** push 5, push 6, then pull `rst_n` low between edges → immediately `count`=0, `empty`=1, `a`=`b`=0, `err`=0. No edge is needed.
- **ALU loop:** push 64, push 27 → `a`=64, `b`=27. Then ALU with `alu_r`=37 → `count`=1, `b`=37, `a`=0, `err`=0.
- **Stack ops:** push 1, push 2, SWAP → `a`=2, `b`=1. OVER → `b`=2, `count`=3. DUP → `b`=2, `count`=4. POP ×4 → `empty`=1.
- **Full boundary (DEPTH=16):** 16 pushes of 0..15 → `full`=1, `b`=15. PUSH 99 → `err` pulse for one cycle, `b`=15, `count`=16. POP → `full`=0, `b`=14.
- **Underflow:** from empty, POP → `err`=1. Push 7, then ALU → `err`=1, `b`=7, `count`=1. Then NOP → `err`=0.
- **Back-to-back illegal:** two consecutive SWAPs with count=1 → `err` stays high for 2 cycles, then drops after the next NOP.
